// File: rtl/spi_pkg.sv
// Shared SPI write-frame constants, FSM state encoding and frame packing helper.
package spi_pkg;

    localparam int FRAME_BITS = 16;
    localparam logic WRITE_BIT = 1'b1;
    localparam int ADDR_BITS = 7;
    localparam int DATA_BITS = 8;
    localparam int BIT_CNT_W = $clog2(FRAME_BITS);

    localparam int STATE_BITS = 3;
    localparam logic [STATE_BITS-1:0] ST_IDLE     = 3'd0;
    localparam logic [STATE_BITS-1:0] ST_SETUP    = 3'd1;
    localparam logic [STATE_BITS-1:0] ST_SHIFT_HI = 3'd2;
    localparam logic [STATE_BITS-1:0] ST_SHIFT_LO = 3'd3;
    localparam logic [STATE_BITS-1:0] ST_HOLD     = 3'd4;
    localparam logic [STATE_BITS-1:0] ST_GAP      = 3'd5;

    typedef struct packed {
        logic                 wr;
        logic [ADDR_BITS-1:0] addr;
        logic [DATA_BITS-1:0] data;
    } frame_t;

    function automatic logic [FRAME_BITS-1:0] build_frame(
        input logic [ADDR_BITS-1:0] addr,
        input logic [DATA_BITS-1:0] data
    );
        frame_t f;
        f.wr   = WRITE_BIT;
        f.addr = addr;
        f.data = data;
        return f;
    endfunction

endpackage

// File: rtl/spi_clk_phase.sv
// Phase counter timing every FSM state to CLK_DIV cycles; strobes on last and next-to-last cycle.
// Latency: strobes are combinational from the counter; counter restarts from 0 after every strobe.
// Backpressure: none; holds at 0 while run is low.
module spi_clk_phase
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic phase_end,
    output logic phase_pre_end
);

    localparam int W = $clog2(CLK_DIV);
    localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);
    localparam logic [W-1:0] PRE  = W'(CLK_DIV - 2);

    logic [W-1:0] cnt;

    assign phase_end     = run && (cnt == LAST);
    assign phase_pre_end = run && (cnt == PRE);

    // Every state lasts exactly CLK_DIV cycles, so wrapping on phase_end reloads on each state change.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!run || phase_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/spi_controller.sv
// SPI mode-0 write-only controller: sends {1, addr[6:0], data[7:0]} MSB first per accepted start.
// Latency: ncs falls the edge after acceptance; done pulses 34*CLK_DIV cycles after acceptance.
// Backpressure: start is ignored while busy; no request queuing.
module spi_controller
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [DATA_BITS-1:0] wr_data,
    output logic                 busy,
    output logic                 done,
    output logic                 sclk,
    output logic                 copi,
    output logic                 ncs
);

    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(FRAME_BITS - 1);

    logic [STATE_BITS-1:0] state;
    logic [FRAME_BITS-1:0] shift_reg;
    logic [FRAME_BITS-1:0] next_frame;
    logic [BIT_CNT_W-1:0]  bit_cnt;
    logic                  running;
    logic                  phase_end;
    logic                  phase_pre_end;

    assign running    = (state != ST_IDLE);
    assign next_frame = build_frame(wr_addr, wr_data);

    spi_clk_phase #(
        .CLK_DIV(CLK_DIV)
    ) u_phase (
        .clk          (clk),
        .rst_n        (rst_n),
        .run          (running),
        .phase_end    (phase_end),
        .phase_pre_end(phase_pre_end)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sclk      <= 1'b0;
            copi      <= 1'b0;
            ncs       <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start && !busy) begin
                        state     <= ST_SETUP;
                        shift_reg <= next_frame;
                        bit_cnt   <= '0;
                        busy      <= 1'b1;
                        ncs       <= 1'b0;
                        copi      <= next_frame[FRAME_BITS-1];
                    end
                end
                ST_SETUP: begin
                    if (phase_end) begin
                        state <= ST_SHIFT_HI;
                        sclk  <= 1'b1;
                    end
                end
                ST_SHIFT_HI: begin
                    if (phase_end) begin
                        sclk <= 1'b0;
                        if (bit_cnt == LAST_BIT) begin
                            state <= ST_HOLD;
                        end else begin
                            // Next bit goes out on the falling edge, a full half-period before the next rise.
                            state     <= ST_SHIFT_LO;
                            bit_cnt   <= bit_cnt + BIT_CNT_W'(1);
                            shift_reg <= shift_reg << 1;
                            copi      <= shift_reg[FRAME_BITS-2];
                        end
                    end
                end
                ST_SHIFT_LO: begin
                    if (phase_end) begin
                        state <= ST_SHIFT_HI;
                        sclk  <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (phase_end) begin
                        state <= ST_GAP;
                        ncs   <= 1'b1;
                        copi  <= 1'b0;
                    end
                end
                ST_GAP: begin
                    // Registered done must be set one cycle early to land on the final gap cycle.
                    if (phase_pre_end) begin
                        done <= 1'b1;
                    end
                    if (phase_end) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    sclk  <= 1'b0;
                    copi  <= 1'b0;
                    ncs   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/spi_controller.md
SPI_CONTROLLER -- requirements
Module: spi_controller

Interface
REQ-001 Parameter CLK_DIV, default 4: sclk half-period in clk cycles; legal range 2..255.
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 rst_n  input  1  reset; synchronous, active-low.
REQ-004 start  input  1  request one write frame; sampled only when busy=0.
REQ-005 wr_addr  input  7  target register address, latched on accepted start.
REQ-006 wr_data  input  8  register data, latched on accepted start.
REQ-007 busy  output  1  high from the cycle after an accepted start until the frame and gap complete.
REQ-008 done  output  1  one-cycle pulse marking frame completion.
REQ-009 sclk  output  1  SPI clock, mode 0 (idle low).
REQ-010 copi  output  1  controller-out data, MSB first.
REQ-011 ncs  output  1  chip select, active low.

Function
REQ-012 The frame SHALL be 16 bits: bit15=1 (write), bits14:8=wr_addr, bits7:0=wr_data, shifted MSB first.
REQ-013 Accepting start SHALL require start=1 and busy=0 at a clk edge; start while busy=1 SHALL be ignored with no queuing.
REQ-014 wr_addr and wr_data SHALL be captured into a 16-bit shift register on acceptance; later input changes SHALL not affect the frame.
REQ-015 FSM states SHALL be IDLE, SETUP, SHIFT_HI, SHIFT_LO, HOLD, GAP.
REQ-016 IDLE: ncs=1, sclk=0, copi=0, busy=0; accepted start -> SETUP.
REQ-017 SETUP: entered the edge after acceptance; ncs=0, sclk=0, copi=frame bit15; lasts CLK_DIV cycles -> SHIFT_HI.
REQ-018 SHIFT_HI: sclk=1 for CLK_DIV cycles, copi stable; after bit 0 -> HOLD, else -> SHIFT_LO.
REQ-019 SHIFT_LO: sclk=0 for CLK_DIV cycles; copi SHALL update to the next bit on the first cycle of the state -> SHIFT_HI.
REQ-020 Exactly 16 sclk rising edges SHALL occur per frame; copi SHALL be stable at least CLK_DIV cycles before and after each rising edge.
REQ-021 HOLD: ncs=0, sclk=0 for CLK_DIV cycles -> GAP.
REQ-022 GAP: ncs=1, sclk=0, copi=0, busy=1 for CLK_DIV cycles; on its last cycle done=1 -> IDLE.
REQ-023 ncs SHALL be low for exactly 33*CLK_DIV cycles per frame; the accept-to-done interval SHALL be 34*CLK_DIV cycles.
REQ-024 Back-to-back: start held high SHALL be accepted in the first IDLE cycle after done, giving CLK_DIV+1 ncs-high cycles between frames.
REQ-025 Bit counter SHALL count 0..15 without wrap; phase counter width SHALL be $clog2(CLK_DIV) bits and reload to 0 at every state change.
REQ-026 Address values are not range-checked; any 7-bit address SHALL be transmitted as given.
REQ-027 All outputs SHALL be registered; no combinational path from start to any SPI pin.

Reset
REQ-028 rst_n=0 at a clk edge SHALL force IDLE: ncs=1, sclk=0, copi=0, busy=0, done=0, shift register and counters 0.
REQ-029 Reset mid-frame SHALL abort with no done pulse; ncs SHALL be 1 on the first edge with rst_n=0.
REQ-030 start during reset SHALL be ignored; the first acceptance is the first edge with rst_n=1 and start=1.

Structure
REQ-031 Package spi_pkg SHALL hold FRAME_BITS=16, WRITE_BIT=1, ADDR_BITS=7, DATA_BITS=8, and the FSM state encoding shared with the SPI peripheral bench.
REQ-032 One sub-module spi_clk_phase SHALL implement the phase counter and emit a phase_end strobe; FSM and shift register stay in spi_controller.

Verification
REQ-033 CLK_DIV=4, start with addr 0x00, data 0xF0 -> copi sampled at sclk rises = 1000_0000_1111_0000; ncs low 132 cycles; done 136 cycles after acceptance.
REQ-034 Loopback into the team SPI peripheral (COPI through its sync flop): write addr 0x04, data 0x80 -> peripheral duty-cycle register reads 0x80; then addr 0x00, data 0xFF -> output-enable register reads 0xFF.
REQ-035 start pulsed at cycle 10 of an active frame with different addr/data -> frame unchanged, no second frame, exactly one done.
REQ-036 start held high for 3 frames -> 3 done pulses, ncs high for exactly 5 cycles between frames (CLK_DIV=4).
REQ-037 rst_n low for 1 cycle after the 7th sclk rise -> ncs=1, sclk=0, busy=0 on that edge, no done; next start produces a complete correct frame.
REQ-038 CLK_DIV=2, addr 0x7F, data 0x55 -> 16 rises, sclk period 4 cycles, bits 1111_1111_0101_0101.
